// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: pre/post-trigger capture of a DDR ADC sample pair stream.
// Samples {B,A} go into a circular DEPTH x 16 RAM. A level crossing on channel A,
// or trig_force, ends the armed phase. The record (PRETRIG samples before the
// trigger, DEPTH-PRETRIG from the trigger on) is then read out over a
// valid/ready port.
// Ports:
//   adc_dco_clk, reset_n        clock (rising edge), async active-low reset
//   adc_data_p / adc_data_n     channel A / channel B samples from the IDDR
//   arm, abort                  start an acquisition / return to IDLE
//   trig_level, trig_edge       unsigned threshold on A, 0=rising 1=falling
//   trig_force                  force a trigger while armed
//   rd_data, rd_valid, rd_ready, rd_last   readout stream, rd_data = {B,A}
//   busy, done                  not idle / one-cycle end-of-record pulse
module adc_trigger_capture #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned PRETRIG    = 256
) (
  input  logic        adc_dco_clk,
  input  logic        reset_n,
  input  logic [7:0]  adc_data_p,
  input  logic [7:0]  adc_data_n,
  input  logic        arm,
  input  logic        abort,
  input  logic [7:0]  trig_level,
  input  logic        trig_edge,
  input  logic        trig_force,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned POSTN = DEPTH - PRETRIG;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ARMED, S_POST, S_READOUT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, prev_a_q, prev_a_d;
  logic [AW-1:0] wptr_q, wptr_d, fill_cnt_q, fill_cnt_d, post_cnt_q, post_cnt_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d, rd_addr_q, rd_addr_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic        rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [15:0] rd_data_q;
  logic [15:0] mem_q [DEPTH];

  logic wr_en_c, ren_c, trig_c, xfer_last_c;

  // Trigger qualification: crossing between previous and current write, or force.
  always_comb begin
    logic rise, fall;
    rise   = (prev_a_q <  trig_level) && (s1_a_q >= trig_level);
    fall   = (prev_a_q >= trig_level) && (s1_a_q <  trig_level);
    trig_c = (trig_edge ? fall : rise) || trig_force;
  end

  assign wr_en_c = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  // The RAM read register doubles as the output register: read only when it is
  // empty or being drained, so a stalled word is held.
  assign ren_c = (state_q == S_READOUT) && (rd_idx_q < CW'(DEPTH)) &&
                 (!rd_valid_q || rd_ready);
  assign xfer_last_c = (state_q == S_READOUT) && rd_valid_q && rd_ready && rd_last_q;

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    s1_a_d     = adc_data_p;
    s1_b_d     = adc_data_n;
    prev_a_d   = prev_a_q;
    wptr_d     = wptr_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    rd_addr_d  = rd_addr_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;

    if (wr_en_c) begin
      wptr_d   = wptr_q + 1'b1;
      prev_a_d = s1_a_q;
    end

    if (ren_c) begin
      rd_addr_d  = rd_addr_q + 1'b1;
      rd_idx_d   = rd_idx_q + 1'b1;
      rd_valid_d = 1'b1;
      rd_last_d  = (rd_idx_q == CW'(DEPTH - 1));
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_FILL;
          wptr_d     = '0;
          fill_cnt_d = '0;
        end
      end
      S_FILL: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == AW'(PRETRIG - 1)) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig_c) begin
          // The trigger sample itself is written at this edge and counts as post sample 1.
          trig_ptr_d = wptr_q;
          post_cnt_d = AW'(1);
          rd_addr_d  = wptr_q - AW'(PRETRIG);
          rd_idx_d   = '0;
          state_d    = (POSTN == 1) ? S_READOUT : S_POST;
        end
      end
      S_POST: begin
        post_cnt_d = post_cnt_q + 1'b1;
        if (post_cnt_q == AW'(POSTN - 1)) begin
          state_d   = S_READOUT;
          rd_addr_d = trig_ptr_q - AW'(PRETRIG);
          rd_idx_d  = '0;
        end
      end
      S_READOUT: begin
        if (xfer_last_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and control registers.
  always_ff @(posedge adc_dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      prev_a_q   <= '0;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      trig_ptr_q <= '0;
      rd_addr_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      prev_a_q   <= prev_a_d;
      wptr_q     <= wptr_d;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      trig_ptr_q <= trig_ptr_d;
      rd_addr_q  <= rd_addr_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Sample RAM write port (contents are not reset).
  always_ff @(posedge adc_dco_clk) begin
    if (wr_en_c) mem_q[wptr_q] <= {s1_b_q, s1_a_q};
  end

  // Registered RAM read, also the rd_data output register.
  always_ff @(posedge adc_dco_clk or negedge reset_n) begin
    if (!reset_n)   rd_data_q <= '0;
    else if (ren_c) rd_data_q <= mem_q[rd_addr_q];
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/adc_trigger_capture.md
ADC_TRIGGER_CAPTURE -- requirements
Module: adc_trigger_capture

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, log2 of buffer depth in sample pairs (DEPTH = 2^DEPTH_LOG2).
REQ-002 The block SHALL have parameter PRETRIG, default 256, number of samples stored before the trigger sample; legal range 1..DEPTH-1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, named as in REQ-004 and REQ-005.
REQ-004 adc_dco_clk  in  1  the ADC DCO clock after BUFR; all logic is clocked on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 adc_data_p  in  8  channel A sample, the IDDR Q1 (rising-edge) output.
REQ-007 adc_data_n  in  8  channel B sample, the IDDR Q2 (falling-edge) output.
REQ-008 arm  in  1  one-cycle request to start an acquisition; honoured only in IDLE.
REQ-009 abort  in  1  synchronous return to IDLE from any state.
REQ-010 trig_level  in  8  unsigned trigger threshold applied to channel A.
REQ-011 trig_edge  in  1  0 = rising crossing, 1 = falling crossing.
REQ-012 trig_force  in  1  forces a trigger while ARMED.
REQ-013 rd_data  out  16  readout word {B,A}, with channel B in [15:8] and channel A in [7:0].
REQ-014 rd_valid  out  1  rd_data is valid.
REQ-015 rd_ready  in  1  consumer accepts the word.
REQ-016 rd_last  out  1  marks the final word of the record; qualified by rd_valid.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse after the last word is transferred.

Function
REQ-019 The block SHALL register adc_data_p and adc_data_n once (stage s1), so that a sample present at edge k is in s1 after edge k and is written to RAM at edge k+1.
REQ-020 The block SHALL use a DEPTH x 16 simple dual-port RAM with 1-cycle registered read and a DEPTH_LOG2-bit write pointer that wraps modulo DEPTH.
REQ-021 The state machine SHALL have the states IDLE, FILL, ARMED, POST and READOUT.
REQ-022 IDLE: no RAM writes, rd_valid=0; on arm=1 go to FILL, with the write pointer and the fill counter cleared.
REQ-023 FILL: write s1 every cycle; after exactly PRETRIG writes go to ARMED; triggers are ignored in this state.
REQ-024 ARMED: write s1 every cycle; prev_a holds the channel A value of the previous write.
REQ-025 A rising trigger SHALL be detected when prev_a < trig_level and s1_a >= trig_level; a falling trigger when prev_a >= trig_level and s1_a < trig_level; both compares are unsigned.
REQ-026 Trigger or trig_force in ARMED: latch trig_ptr as the write address of the current s1 sample, and go to POST at that same edge.
REQ-027 POST: continue writing until DEPTH-PRETRIG samples, including the trigger sample, have been written since the trigger, then go to READOUT; during POST the pointer may overwrite the oldest pre-trigger data only beyond DEPTH.
REQ-028 READOUT: emit exactly DEPTH words, in order, starting at address (trig_ptr - PRETRIG) mod DEPTH; the word with index PRETRIG is the trigger sample.
REQ-029 Readout handshake: a word transfers on an edge where rd_valid=1 and rd_ready=1.
REQ-030 rd_data, rd_valid and rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-031 Readout SHALL sustain 1 word per cycle when rd_ready is held high, with the first rd_valid no later than 2 cycles after entering READOUT; use a skid or output register so that no word is dropped or duplicated.
REQ-032 rd_last SHALL be 1 only on word DEPTH-1.
REQ-033 After the last word transfers, the block SHALL go to IDLE and assert done for exactly 1 cycle.
REQ-034 An arm asserted outside IDLE SHALL be ignored.
REQ-035 arm and abort asserted in the same cycle: abort wins.
REQ-036 abort in any state: IDLE at the next edge, rd_valid=0 and busy=0 at that edge, no done pulse.
REQ-037 trig_force and a level crossing in the same cycle SHALL produce a single trigger.

Reset
REQ-038 On reset_n=0 the state SHALL be IDLE and the pointers and counters zero, with outputs rd_valid=0, rd_last=0, busy=0, done=0 and rd_data=0; RAM contents are not reset.
REQ-039 Reset asserted mid-acquisition or mid-readout SHALL abandon the record; after release, a new arm SHALL be required.

Verification (DEPTH_LOG2=4, PRETRIG=4)
REQ-040 Ramp A=0,1,2,... with B=~A, trig_level=10, trig_edge=0, arm, rd_ready=1 -> 16 words with A=6..21, word 4 A=10, rd_last on word 15, done 1 cycle.
REQ-041 Same ramp, with rd_ready toggling 1/0 randomly -> identical 16 words, none lost or duplicated, and rd_data stable while stalled.
REQ-042 A held at 200, trig_edge=1, trig_level=100, then A=50 -> trigger on the 50 sample (word 4 A=50, words 0..3 A=200).
REQ-043 Crossing presented during FILL only, then constant A -> no trigger; trig_force -> record with word 4 = the sample at force.
REQ-044 abort during POST, and reset_n low during READOUT -> IDLE, busy=0, no done; a following arm yields a complete, correct record.
REQ-045 arm pulsed during ARMED and READOUT -> ignored; exactly one record and one done pulse.
